lz_normalizer: RTL and testbench

LZ_NORMALIZER -- requirements
Module: lz_normalizer

---
 rtl/lz_normalizer_if.sv | 25 ++
 rtl/lz_normalizer.sv | 108 ++++++++++
 tb/tb_lz_normalizer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lz_normalizer_if.sv
// Handshake bundle for lz_normalizer: an input word stream and a normalized result stream.
interface lz_normalizer_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_shift;
    logic             out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_zero
    );
endinterface

// File: rtl/lz_normalizer.sv
// Multi-cycle leading-zero normalizer: scans one CHUNK-bit slice per cycle from the MSB,
// then barrel-shifts the word left so its MSB is 1 (or reports an all-zero word).
module lz_normalizer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst,
    lz_normalizer_if.slave bus
);
    localparam int SW     = $clog2(WIDTH + 1);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SW-1:0]    count;
    logic [IW-1:0]    idx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_zero_q;

    logic [CHUNK-1:0] slice;
    logic [CW-1:0]    slice_lz;
    logic             slice_nz;
    logic             last_slice;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        slice      = work[WIDTH-1-int'(idx)*CHUNK -: CHUNK];
        slice_nz   = |slice;
        last_slice = (idx == IW'(NCHUNK - 1));
        slice_lz   = '0;
        // Ascending scan: the highest set bit writes last and wins.
        for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) slice_lz = CW'(CHUNK - 1 - i);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            work        <= '0;
            count       <= '0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.in_data;
                        count      <= '0;
                        idx        <= '0;
                        out_zero_q <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (slice_nz) begin
                        count <= count + SW'(slice_lz);
                        state <= SHIFT;
                    end else if (last_slice) begin
                        count       <= SW'(WIDTH);
                        out_zero_q  <= 1'b1;
                        work        <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + SW'(CHUNK);
                        idx   <= idx + IW'(1);
                    end
                end
                SHIFT: begin
                    work        <= work << count;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work;
    assign bus.out_shift = count;
    assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_lz_normalizer.sv
// Directed and random checks of lz_normalizer (WIDTH=32, CHUNK=8) against a bit-serial model.
module tb_lz_normalizer;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NRAND = 10000;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  shift;
        logic        zero;
    } result_t;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    lz_normalizer_if #(.WIDTH(WIDTH)) bus ();

    lz_normalizer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input logic [31:0] x);
        result_t r;
        int n;
        n = 0;
        while (n < 32 && x[31-n] == 1'b0) n++;
        r.shift = 6'(n);
        r.zero  = (x == 32'h0);
        r.data  = (n == 32) ? 32'h0 : (x << n);
        return r;
    endfunction

    // Offer a word in IDLE, then count edges from the accept edge until out_valid.
    task automatic accept_word(input logic [31:0] d, input int elat, input string tag);
        int lat;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
    endtask

    task automatic check_out(input logic [31:0] ed, input int es, input logic ez, input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_data"}, 64'(bus.out_data), 64'(ed));
        check({tag, "_shift"}, 64'(bus.out_shift), 64'(es));
        check({tag, "_zero"}, 64'(bus.out_zero), 64'(ez));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_ready_back"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_word(input logic [31:0] d, input logic [31:0] ed, input int es,
                            input logic ez, input int elat, input string tag);
        accept_word(d, elat, tag);
        check_out(ed, es, ez, tag);
        handshake(tag);
    endtask

    initial begin
        result_t     q[$];
        result_t     exp;
        logic [31:0] word;
        int          sent;
        int          got;
        int          cyc;
        int          stray;
        logic        acc;
        logic        hs;

        tests         = 0;
        failed        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_shift", 64'(bus.out_shift), 64'(0));
        check("rst_out_zero", 64'(bus.out_zero), 64'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        @(posedge clk); #1;

        run_word(32'h8000_0000, 32'h8000_0000, 0, 1'b0, 2, "msb_set");
        run_word(32'h0012_3456, 32'h91A2_B000, 11, 1'b0, 3, "mid");
        run_word(32'h0000_0001, 32'h8000_0000, 31, 1'b0, 5, "lsb_only");
        run_word(32'h0000_0000, 32'h0000_0000, 32, 1'b1, 4, "all_zero");

        // Stall in DONE with a competing word offered.
        accept_word(32'h0000_8000, 4, "hold");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0F00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_out(32'h8000_0000, 16, 1'b0, "hold_stall");
            check("hold_in_ready", 64'(bus.in_ready), 64'(0));
        end
        handshake("hold");
        run_word(32'h0000_0F00, 32'hF000_0000, 20, 1'b0, 4, "after_hold");

        // Reset mid-scan, with out_ready high at the same edge.
        bus.in_data  = 32'h0000_00FF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("scan_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out_data", 64'(bus.out_data), 64'(0));
        check("midrst_out_shift", 64'(bus.out_shift), 64'(0));
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray++;
        end
        check("midrst_no_output", 64'(stray), 64'(0));
        run_word(32'h0100_0000, 32'h8000_0000, 7, 1'b0, 2, "post_rst");

        // Back-to-back random words with random backpressure, scoreboarded in order.
        sent = 0;
        got  = 0;
        cyc  = 0;
        word = $urandom() >> $urandom_range(0, 32);
        bus.in_data = word;
        while (got < NRAND && cyc < 90000) begin
            bus.in_valid  = (sent < NRAND);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_output", 64'(1), 64'(0));
                end else begin
                    exp = q.pop_front();
                    check("rand_result", 64'({bus.out_data, bus.out_shift, bus.out_zero}), 64'(exp));
                end
                got++;
            end
            if (acc) begin
                q.push_back(model(word));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                word = $urandom() >> $urandom_range(0, 32);
                bus.in_data = word;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("rand_received", 64'(got), 64'(NRAND));
        check("rand_leftover", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
